// File: rtl/cpu_pkg.sv
// Shared constants and the bus-select encoding used by the bus and the control unit.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int NARROW_W = 8;

  typedef enum logic [2:0] {
    SEL_IDLE = 3'd0,
    SEL_R    = 3'd1,
    SEL_DR   = 3'd2,
    SEL_TR   = 3'd3,
    SEL_PC   = 3'd4,
    SEL_AC   = 3'd5,
    SEL_DM   = 3'd6,
    SEL_IM   = 3'd7
  } bus_sel_e;

endpackage

// File: rtl/bus_mux.sv
// Combinational 7:1 source select; narrow sources are zero-extended to the bus width.
module bus_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NARROW_W = cpu_pkg::NARROW_W
) (
  input  logic [2:0]          sel_i,
  input  logic [NARROW_W-1:0] r_i,
  input  logic [NARROW_W-1:0] dr_i,
  input  logic [DATA_W-1:0]   tr_i,
  input  logic [NARROW_W-1:0] pc_i,
  input  logic [DATA_W-1:0]   ac_i,
  input  logic [NARROW_W-1:0] dm_i,
  input  logic [NARROW_W-1:0] im_i,
  output logic [DATA_W-1:0]   mux_o,
  output logic                active_o
);

  // Pick the narrow source first so zero-extension is written once and works when NARROW_W == DATA_W.
  logic [NARROW_W-1:0] narrowSel;
  logic                useWide;
  logic [DATA_W-1:0]   wideSel;

  always_comb begin
    narrowSel = '0;
    wideSel   = '0;
    useWide   = 1'b0;
    active_o  = 1'b1;
    case (sel_i)
      SEL_R:   narrowSel = r_i;
      SEL_DR:  narrowSel = dr_i;
      SEL_TR:  begin wideSel = tr_i; useWide = 1'b1; end
      SEL_PC:  narrowSel = pc_i;
      SEL_AC:  begin wideSel = ac_i; useWide = 1'b1; end
      SEL_DM:  narrowSel = dm_i;
      SEL_IM:  narrowSel = im_i;
      default: active_o = 1'b0;
    endcase
  end

  always_comb begin
    mux_o = '0;
    if (useWide) begin
      mux_o = wideSel;
    end else begin
      mux_o[NARROW_W-1:0] = narrowSel;
    end
  end

endmodule

// File: rtl/bus.sv
// Central datapath bus: registered one-cycle view of the selected source plus a valid flag.
module bus
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NARROW_W = cpu_pkg::NARROW_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          read_en,
  input  logic [NARROW_W-1:0] r,
  input  logic [NARROW_W-1:0] dr,
  input  logic [DATA_W-1:0]   tr,
  input  logic [NARROW_W-1:0] pc,
  input  logic [DATA_W-1:0]   ac,
  input  logic [NARROW_W-1:0] dm,
  input  logic [NARROW_W-1:0] im,
  output logic [DATA_W-1:0]   busout,
  output logic                bus_valid
);

  logic [DATA_W-1:0] muxOut;
  logic              muxActive;
  logic [DATA_W-1:0] busout_d, busout_q;
  logic              valid_d, valid_q;

  bus_mux #(
    .DATA_W  (DATA_W),
    .NARROW_W(NARROW_W)
  ) u_mux (
    .sel_i   (read_en),
    .r_i     (r),
    .dr_i    (dr),
    .tr_i    (tr),
    .pc_i    (pc),
    .ac_i    (ac),
    .dm_i    (dm),
    .im_i    (im),
    .mux_o   (muxOut),
    .active_o(muxActive)
  );

  // Idle keeps the last value on the bus but drops valid.
  always_comb begin
    busout_d = busout_q;
    valid_d  = muxActive;
    if (muxActive) begin
      busout_d = muxOut;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busout_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      busout_q <= busout_d;
      valid_q  <= valid_d;
    end
  end

  assign busout    = busout_q;
  assign bus_valid = valid_q;

endmodule

// File: tb/tb_bus.sv
// Self-checking bench for bus: vector table through a scoreboard queue, plus reset and sampling sequences.
module tb_bus;

  logic        clk;
  logic        rst_n;
  logic [2:0]  read_en;
  logic [7:0]  r, dr, pc, dm, im;
  logic [15:0] tr, ac;
  logic [15:0] busout;
  logic        bus_valid;

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  r, dr, pc, dm, im;
    logic [15:0] tr, ac;
    logic [15:0] expBus;
    logic        expValid;
  } vec_t;

  typedef struct packed {
    logic [15:0] bus;
    logic        valid;
  } exp_t;

  vec_t vecs[16];
  exp_t sbq[$];
  int   assertions = 0;
  int   failures   = 0;

  bus dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read_en  (read_en),
    .r        (r),
    .dr       (dr),
    .tr       (tr),
    .pc       (pc),
    .ac       (ac),
    .dm       (dm),
    .im       (im),
    .busout   (busout),
    .bus_valid(bus_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [2:0] sel, logic [7:0] vr, logic [7:0] vdr, logic [15:0] vtr,
                              logic [7:0] vpc, logic [15:0] vac, logic [7:0] vdm, logic [7:0] vim,
                              logic [15:0] eb, logic ev);
    vec_t v;
    v.sel = sel; v.r = vr; v.dr = vdr; v.tr = vtr; v.pc = vpc;
    v.ac = vac; v.dm = vdm; v.im = vim; v.expBus = eb; v.expValid = ev;
    return v;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    exp_t e;
    @(negedge clk);
    read_en = v.sel; r = v.r; dr = v.dr; tr = v.tr; pc = v.pc;
    ac = v.ac; dm = v.dm; im = v.im;
    e.bus = v.expBus;
    e.valid = v.expValid;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL %s: scoreboard empty, got 0x%04h expected an entry", name, busout);
    end else begin
      e = sbq.pop_front();
      check({name, ".busout"}, busout, e.bus);
      check({name, ".valid"}, {15'd0, bus_valid}, {15'd0, e.valid});
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation timeout, got no end, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = mk(3'd0, 8'h00, 8'h00, 16'h0000, 8'h00, 16'h0000, 8'h00, 8'h00, 16'h0000, 1'b0);
    vecs[1]  = mk(3'd1, 8'h01, 8'h01, 16'h0001, 8'h01, 16'h0001, 8'h01, 8'h01, 16'h0001, 1'b1);
    vecs[2]  = mk(3'd1, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'hBEEF, 8'hD4, 8'hE5, 16'h00A1, 1'b1);
    vecs[3]  = mk(3'd2, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'hBEEF, 8'hD4, 8'hE5, 16'h00B2, 1'b1);
    vecs[4]  = mk(3'd3, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'hBEEF, 8'hD4, 8'hE5, 16'h1234, 1'b1);
    vecs[5]  = mk(3'd4, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'hBEEF, 8'hD4, 8'hE5, 16'h00C3, 1'b1);
    vecs[6]  = mk(3'd5, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'hBEEF, 8'hD4, 8'hE5, 16'hBEEF, 1'b1);
    vecs[7]  = mk(3'd6, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'hBEEF, 8'hD4, 8'hE5, 16'h00D4, 1'b1);
    vecs[8]  = mk(3'd7, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'hBEEF, 8'hD4, 8'hE5, 16'h00E5, 1'b1);
    vecs[9]  = mk(3'd5, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'hBEEF, 8'hD4, 8'hE5, 16'hBEEF, 1'b1);
    vecs[10] = mk(3'd0, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'h0000, 8'hD4, 8'hE5, 16'hBEEF, 1'b0);
    vecs[11] = mk(3'd0, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'h0000, 8'hD4, 8'hE5, 16'hBEEF, 1'b0);
    vecs[12] = mk(3'd0, 8'hA1, 8'hB2, 16'h1234, 8'hC3, 16'h0000, 8'hD4, 8'hE5, 16'hBEEF, 1'b0);
    vecs[13] = mk(3'd5, 8'hFF, 8'hFF, 16'h8001, 8'hFF, 16'hFFFF, 8'hFF, 8'hFF, 16'hFFFF, 1'b1);
    vecs[14] = mk(3'd4, 8'hFF, 8'h00, 16'hFFFF, 8'hFF, 16'h0000, 8'h00, 8'h00, 16'h00FF, 1'b1);
    vecs[15] = mk(3'd2, 8'h00, 8'h11, 16'hFFFF, 8'h00, 16'hFFFF, 8'h00, 8'h00, 16'h0011, 1'b1);

    rst_n = 1'b0; read_en = 3'd0;
    r = '0; dr = '0; tr = '0; pc = '0; ac = '0; dm = '0; im = '0;
    #12;
    check("reset.busout", busout, 16'h0000);
    check("reset.valid", {15'd0, bus_valid}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // dr changes between edges: bus must still show the value captured at the last edge
    @(negedge clk);
    dr = 8'h22;
    #1;
    check("sample.hold", busout, 16'h0011);
    sbq.push_back('{bus: 16'h0022, valid: 1'b1});
    checkOutput("sample.next");

    // Load 0x1234, then assert reset mid-cycle with no clock edge
    applyStimulus(mk(3'd3, 8'h00, 8'h00, 16'h1234, 8'h00, 16'h0000, 8'h00, 8'h00, 16'h1234, 1'b1));
    checkOutput("preReset");
    #2;
    rst_n = 1'b0;
    #1;
    check("asyncReset.busout", busout, 16'h0000);
    check("asyncReset.valid", {15'd0, bus_valid}, 16'h0000);

    // Release reset with a pending select; nothing changes until the next rising edge
    @(negedge clk);
    read_en = 3'd3;
    tr = 16'hFFFF;
    rst_n = 1'b1;
    #1;
    check("recover.before", busout, 16'h0000);
    check("recover.beforeValid", {15'd0, bus_valid}, 16'h0000);
    sbq.push_back('{bus: 16'hFFFF, valid: 1'b1});
    checkOutput("recover.after");

    assertions++;
    if (sbq.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard.drain: %0d left, expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/bus.md
Name: bus

Overview:
- Central datapath bus of the simple accumulator processor.
- Selects one of seven register/memory sources (R, DR, TR, PC, AC, DM, IM) using a 3-bit read-enable code.
- Zero-extends 8-bit sources and presents the selected value as a registered 16-bit bus value, sampled by downstream registers on the next clock edge.

Parameters:
- DATA_W, 16, bus width and width of the wide sources (tr, ac).
- NARROW_W, 8, width of the narrow sources (r, dr, pc, dm, im); must be ≤ DATA_W.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- read_en  input  3  source select code.
- r  input  NARROW_W  general register R.
- dr  input  NARROW_W  data register.
- tr  input  DATA_W  temporary register.
- pc  input  NARROW_W  program counter.
- ac  input  DATA_W  accumulator.
- dm  input  NARROW_W  data-memory read data.
- im  input  NARROW_W  instruction-memory read data.
- busout  output  DATA_W  registered bus value.
- bus_valid  output  1  high for the cycle after a non-idle select was sampled.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, any time, independent of clk):
  - busout=0, bus_valid=0 immediately.
  - Both outputs stay there until the first rising edge after rst_n deasserts.
  - Reset mid-operation discards the current selection.
- Select decode of read_en, sampled on the rising clk:
  - 0 = idle
  - 1 = r
  - 2 = dr
  - 3 = tr
  - 4 = pc
  - 5 = ac
  - 6 = dm
  - 7 = im
- Width rules:
  - Narrow sources are zero-extended to DATA_W (upper DATA_W-NARROW_W bits = 0).
  - tr and ac pass through at full width, no truncation.
- Latency: one cycle.
  - At rising edge N, busout takes the selected source value present at edge N.
  - bus_valid is set to 1 at the same edge.
- Idle (read_en=0):
  - busout holds its previous value.
  - bus_valid is 0 after that edge.
- Back-to-back selects:
  - Each edge independently samples read_en.
  - No handshake and no stall; a new select every cycle is legal.
- Source changes between edges have no effect on busout until the next edge.
- X/unknown on read_en is not handled specially; the bench drives only defined codes after reset.
- All decoding is purely combinational ahead of a single output register. Mutual exclusion of sources is guaranteed by the encoded select, so no bus contention is possible.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W and NARROW_W constants.
  - Enumerated bus-select typedef (SEL_IDLE, SEL_R, SEL_DR, SEL_TR, SEL_PC, SEL_AC, SEL_DM, SEL_IM = 0..7), reused by the control unit that drives read_en.
- Optional sub-module: bus_mux, the combinational 7:1 select with zero-extension. The bus module wraps it with the output register and the valid flag.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with busout previously 0x1234 → busout=0x0000 and bus_valid=0 immediately, without waiting for a clock edge.
- Basic select: read_en=1, all sources=1 → after next edge busout=0x0001, bus_valid=1.
- Zero-extension and selection: r=0xA1, dr=0xB2, pc=0xC3, dm=0xD4, im=0xE5, tr=0x1234, ac=0xBEEF. Step read_en 1..7 on consecutive edges → busout sequence 0x00A1, 0x00B2, 0x1234, 0x00C3, 0xBEEF, 0x00D4, 0x00E5, each one cycle after its select, bus_valid=1 throughout.
- Idle hold: after ac=0xBEEF was selected, set read_en=0 for 3 cycles while changing ac to 0x0000 → busout stays 0xBEEF, bus_valid=0.
- Sampling timing: read_en=2, change dr from 0x11 to 0x22 between edges → busout shows 0x0011 until the following edge, then 0x0022.
- Reset recovery: deassert rst_n with read_en=3, tr=0xFFFF → busout=0x0000 until the first rising edge, then 0xFFFF.
